// File: rtl/action_ram_pkg.sv
// Shared types and constants for the action RAM scheduler and its return pipeline.
package action_ram_pkg;

    localparam int ACT_DATA_W = 16;
    localparam int ACT_ADDR_W = 8;
    localparam int RD_LAT_MAX = 4;

    typedef enum logic [0:0] {
        PRIO_RD = 1'b0,
        PRIO_WR = 1'b1
    } prio_t;

endpackage

// File: rtl/action_ram_sched_rd_return_pipe.sv
// Read return pipeline: tags each issued read with a valid bit and delivers the
// RAM word on the cycle it arrives, holding the last word between strobes.
module rd_return_pipe
    import action_ram_pkg::*;
#(
    parameter int DATA_W = ACT_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy
);

    logic [RD_LAT:0]   vld_r;
    logic [DATA_W-1:0] hold_r;

    // Valid-bit shift register; stage 0 lines up with the registered RAM command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_r <= '0;
        end else begin
            vld_r <= {vld_r[RD_LAT-1:0], issue};
        end
    end

    // Keep the most recently returned word for the idle cycles between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_r <= '0;
        end else if (vld_r[RD_LAT]) begin
            hold_r <= ram_rdata;
        end else begin
            hold_r <= hold_r;
        end
    end

    // The strobe cycle is the cycle the RAM word is valid, so it is forwarded
    // directly then; the held copy covers every other cycle.
    assign rd_valid = vld_r[RD_LAT];
    assign rd_data  = vld_r[RD_LAT] ? ram_rdata : hold_r;
    assign busy     = |vld_r;

endmodule

// File: rtl/action_ram_sched.sv
// Round-robin scheduler sharing one action RAM port between the policy read
// requester and the Q-update write requester.
module action_ram_sched
    import action_ram_pkg::*;
#(
    parameter int DATA_W = ACT_DATA_W,
    parameter int ADDR_W = ACT_ADDR_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    prio_t             state_r;
    prio_t             next_state_s;
    logic              rd_gnt_s;
    logic              wr_gnt_s;
    logic              ram_en_r;
    logic              ram_we_r;
    logic [ADDR_W-1:0] ram_addr_r;
    logic [DATA_W-1:0] ram_wdata_r;

    // Arbitration: a lone requester always wins; on contention the state picks,
    // and every grant hands priority to the other side.
    always_comb begin
        rd_gnt_s     = 1'b0;
        wr_gnt_s     = 1'b0;
        next_state_s = state_r;
        if (rst) begin
            next_state_s = state_r;
        end else if (rd_req && wr_req) begin
            case (state_r)
                PRIO_RD: begin
                    rd_gnt_s     = 1'b1;
                    next_state_s = PRIO_WR;
                end
                PRIO_WR: begin
                    wr_gnt_s     = 1'b1;
                    next_state_s = PRIO_RD;
                end
                default: begin
                    rd_gnt_s     = 1'b1;
                    next_state_s = PRIO_WR;
                end
            endcase
        end else if (rd_req) begin
            rd_gnt_s     = 1'b1;
            next_state_s = PRIO_WR;
        end else if (wr_req) begin
            wr_gnt_s     = 1'b1;
            next_state_s = PRIO_RD;
        end else begin
            next_state_s = state_r;
        end
    end

    // Priority state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= PRIO_RD;
        end else begin
            state_r <= next_state_s;
        end
    end

    // RAM command register; write data is only reloaded by write grants.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_en_r    <= 1'b0;
            ram_we_r    <= 1'b0;
            ram_addr_r  <= '0;
            ram_wdata_r <= '0;
        end else begin
            ram_en_r <= rd_gnt_s | wr_gnt_s;
            ram_we_r <= wr_gnt_s;
            if (wr_gnt_s) begin
                ram_addr_r  <= wr_addr;
                ram_wdata_r <= wr_data;
            end else if (rd_gnt_s) begin
                ram_addr_r  <= rd_addr;
                ram_wdata_r <= ram_wdata_r;
            end else begin
                ram_addr_r  <= ram_addr_r;
                ram_wdata_r <= ram_wdata_r;
            end
        end
    end

    assign rd_gnt    = rd_gnt_s;
    assign wr_gnt    = wr_gnt_s;
    assign ram_en    = ram_en_r;
    assign ram_we    = ram_we_r;
    assign ram_addr  = ram_addr_r;
    assign ram_wdata = ram_wdata_r;

    rd_return_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_return_pipe (
        .clk       (clk),
        .rst       (rst),
        .issue     (rd_gnt_s),
        .ram_rdata (ram_rdata),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .busy      (busy)
    );

endmodule
